// File: rtl/lcd_feeder_pkg.sv
// Shared types and defaults for the LCD character feeder.
// Optional watchdog build switch: LCD_FEEDER_TIMEOUT_EN.
package lcd_feeder_pkg;

  localparam int CHAR_W                 = 8;
  localparam int DEFAULT_DEPTH          = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_BUSY  = 2'd2,
    ST_WAIT_READY = 2'd3
  } state_e;

endpackage

// File: rtl/lcd_char_feeder_if.sv
// Character FIFO port bundle: the sequencer is the master, the storage is the slave.
interface lcd_char_feeder_if
  import lcd_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
);
  logic                     push;
  logic [CHAR_W-1:0]        push_data;
  logic                     pop;
  logic [CHAR_W-1:0]        head;
  logic [$clog2(DEPTH):0]   level;
  logic                     full;
  logic                     empty;

  modport master (output push, push_data, pop, input head, level, full, empty);
  modport slave  (input push, push_data, pop, output head, level, full, empty);
endinterface

// File: rtl/char_fifo.sv
// Character FIFO with synchronous push/pop, occupancy output and async active-low reset.
module char_fifo
  import lcd_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_char_feeder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push, do_pop;

  assign bus.full  = (level_q == LW'(DEPTH));
  assign bus.empty = (level_q == '0);
  assign bus.level = level_q;
  assign bus.head  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even if the same edge pops.
  assign do_push = bus.push && !bus.full;
  assign do_pop  = bus.pop  && !bus.empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.push_data;
  end

endmodule

// File: rtl/lcd_char_feeder.sv
// Buffers characters and feeds them one at a time to an LCD driver via a strobe/ready handshake.
// Define LCD_FEEDER_TIMEOUT_EN to add the sticky oTimeout output and handshake watchdog.
module lcd_char_feeder
  import lcd_feeder_pkg::*;
#(
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   iValid,
  input  logic [CHAR_W-1:0]      iChar,
  output logic                   oAccept,
  input  logic                   iLCD_Ready,
  input  logic                   iLCD_Initialized,
  output logic                   oWrite_Enabled,
  output logic [CHAR_W-1:0]      oData,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oBusy
`ifdef LCD_FEEDER_TIMEOUT_EN
  ,
  output logic                   oTimeout
`endif
);

  lcd_char_feeder_if #(.DEPTH(DEPTH)) fifo_bus ();

  state_e            state_q, state_d;
  logic [CHAR_W-1:0] data_q, data_d;
  logic              pop;

  assign fifo_bus.push      = iValid;
  assign fifo_bus.push_data = iChar;
  assign fifo_bus.pop       = pop;

  char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clock),
    .rst_n (Reset_n),
    .bus   (fifo_bus.slave)
  );

`ifdef LCD_FEEDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  assign oTimeout = timeout_q;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
`ifdef LCD_FEEDER_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
`ifdef LCD_FEEDER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // NOTE: every signal gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef LCD_FEEDER_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_bus.empty && iLCD_Ready && iLCD_Initialized) begin
          pop     = 1'b1;
          data_d  = fifo_bus.head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:      state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY:  if (!iLCD_Ready) state_d = ST_WAIT_READY;
      ST_WAIT_READY: if (iLCD_Ready)  state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
`ifdef LCD_FEEDER_TIMEOUT_EN
    // One budget covers the whole handshake, spanning both wait states.
    if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_READY) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  assign oAccept        = !fifo_bus.full;
  assign oLevel         = fifo_bus.level;
  assign oData          = data_q;
  assign oWrite_Enabled = (state_q == ST_ISSUE);
  assign oBusy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Self-checking bench for lcd_char_feeder; a strobe monitor compares every write against a scoreboard queue.
module tb_lcd_char_feeder;
  import lcd_feeder_pkg::*;

  localparam int DEPTH = 16;
`ifdef LCD_FEEDER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = DEFAULT_TIMEOUT_CYCLES;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        accept, lcd_ready, lcd_init, we, busy;
  logic [7:0]  data;
`ifdef LCD_FEEDER_TIMEOUT_EN
  logic        timeout;
`endif

  lcd_char_feeder_if #(.DEPTH(DEPTH)) prod_if ();

  int          checks = 0;
  int          passes = 0;
  int          strobes = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  always #5 clk = ~clk;

  lcd_char_feeder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock            (clk),
    .Reset_n          (rst_n),
    .iValid           (prod_if.push),
    .iChar            (prod_if.push_data),
    .oAccept          (accept),
    .iLCD_Ready       (lcd_ready),
    .iLCD_Initialized (lcd_init),
    .oWrite_Enabled   (we),
    .oData            (data),
    .oLevel           (prod_if.level),
    .oBusy            (busy)
`ifdef LCD_FEEDER_TIMEOUT_EN
    ,
    .oTimeout         (timeout)
`endif
  );

  assign prod_if.full  = !accept;
  assign prod_if.empty = (prod_if.level == '0);
  assign prod_if.pop   = we;
  assign prod_if.head  = data;

  // Scoreboard: every strobe must carry the oldest accepted character.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL strobe_order: unexpected strobe data=%h, expected no strobe", data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data !== mon_exp) $display("FAIL strobe_order: data=%h expected=%h", data, mon_exp);
        else passes++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    prod_if.push = 1'b0;
    prod_if.push_data = '0;
    lcd_ready = 1'b0;
    lcd_init = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_char(input logic [7:0] c, input bit exp_acc);
    prod_if.push = 1'b1;
    prod_if.push_data = c;
    if (exp_acc) exp_q.push_back(c);
    @(negedge clk);
    prod_if.push = 1'b0;
  endtask

  task automatic wait_strobe(input int bound, output bit seen);
    int n = 0;
    while (we !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    seen = (we === 1'b1);
  endtask

  task automatic lcd_serve(input int n, input int busy_len);
    bit seen;
    for (int k = 0; k < n; k++) begin
      wait_strobe(50, seen);
      checks++;
      if (!seen) $display("FAIL serve_strobe: char %0d no strobe within bound, expected strobe", k);
      else passes++;
      @(negedge clk);
      lcd_ready = 1'b0;
      repeat (busy_len) @(negedge clk);
      lcd_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    prod_if.push = 1'b0;
    prod_if.push_data = '0;
    lcd_ready = 1'b1;
    lcd_init = 1'b0;
    #1;
    checks += 5;
    if (prod_if.level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", prod_if.level); else passes++;
    if (accept !== 1'b1)        $display("FAIL reset_accept: got %b expected 1", accept); else passes++;
    if (we !== 1'b0)            $display("FAIL reset_we: got %b expected 0", we); else passes++;
    if (busy !== 1'b0)          $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    if (data !== 8'h00)         $display("FAIL reset_data: got %h expected 00", data); else passes++;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    prod_if.push = 1'b1;
    prod_if.push_data = 8'h5A;
    #2;
    checks++;
    if (prod_if.level !== 5'd0) $display("FAIL release_no_edge: level %0d expected 0", prod_if.level); else passes++;
    @(posedge clk);
    #1;
    prod_if.push = 1'b0;
    checks++;
    if (prod_if.level !== 5'd1) $display("FAIL release_first_push: level %0d expected 1", prod_if.level); else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    lcd_init = 1'b1;
    lcd_ready = 1'b1;
    push_char(8'h41, 1'b1);
    checks++;
    if (we !== 1'b0) $display("FAIL basic_latency_early: we=%b expected 0", we); else passes++;
    @(negedge clk);
    checks++;
    if (we !== 1'b1 || data !== 8'h41) $display("FAIL basic_strobe: we=%b data=%h expected 1/41", we, data); else passes++;
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || data !== 8'h41 || busy !== 1'b1)
      $display("FAIL basic_hold: we=%b data=%h busy=%b expected 0/41/1", we, data, busy);
    else passes++;
    lcd_ready = 1'b0;
    @(negedge clk);
    lcd_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL basic_idle: busy=%b pending=%0d expected 0/0", busy, exp_q.size());
    else passes++;
  endtask

  task automatic test_handshake();
    bit seen;
    int s0;
    do_reset();
    lcd_init = 1'b1;
    lcd_ready = 1'b1;
    push_char(8'h48, 1'b1);
    push_char(8'h49, 1'b1);
    wait_strobe(20, seen);
    checks++;
    if (!seen) $display("FAIL hs_first_strobe: no strobe within bound, expected strobe"); else passes++;
    @(negedge clk);
    lcd_ready = 1'b0;
    s0 = strobes;
    repeat (3000) @(negedge clk);
    checks++;
    if (strobes != s0) $display("FAIL hs_no_strobe_while_busy: %0d strobes expected 0", strobes - s0); else passes++;
    lcd_ready = 1'b1;
    wait_strobe(50, seen);
    checks++;
    if (!seen || data !== 8'h49) $display("FAIL hs_second_strobe: seen=%b data=%h expected 1/49", seen, data); else passes++;
    @(negedge clk);
    lcd_ready = 1'b0;
    @(negedge clk);
    lcd_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL hs_drained: pending=%0d expected 0", exp_q.size()); else passes++;
  endtask

  task automatic test_full();
    bit exp_acc;
    do_reset();
    lcd_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_acc = (i < DEPTH);
      checks++;
      if (accept !== exp_acc) $display("FAIL full_accept: push %0d accept=%b expected %b", i, accept, exp_acc); else passes++;
      push_char(8'h60 + 8'(i), exp_acc);
    end
    checks++;
    if (prod_if.level !== 5'd16 || accept !== 1'b0)
      $display("FAIL full_level: level=%0d accept=%b expected 16/0", prod_if.level, accept);
    else passes++;
    lcd_init = 1'b1;
    lcd_serve(16, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || prod_if.level !== 5'd0)
      $display("FAIL full_drain: pending=%0d level=%0d expected 0/0", exp_q.size(), prod_if.level);
    else passes++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    lcd_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_char(8'h30 + 8'(i), 1'b1);
    checks++;
    if (prod_if.level !== 5'd5) $display("FAIL simul_prefill: level=%0d expected 5", prod_if.level); else passes++;
    lcd_init = 1'b1;
    push_char(8'h35, 1'b1);
    checks++;
    if (prod_if.level !== 5'd5 || we !== 1'b1)
      $display("FAIL simul_level: level=%0d we=%b expected 5/1", prod_if.level, we);
    else passes++;
    lcd_serve(6, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL simul_drain: pending=%0d expected 0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_midop();
    bit seen;
    do_reset();
    lcd_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_char(8'h70 + 8'(i), 1'b1);
    lcd_init = 1'b1;
    wait_strobe(10, seen);
    @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b1 || prod_if.level !== 5'd3)
      $display("FAIL midop_setup: seen=%b busy=%b level=%0d expected 1/1/3", seen, busy, prod_if.level);
    else passes++;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (prod_if.level !== 5'd0 || busy !== 1'b0 || we !== 1'b0 || data !== 8'h00)
      $display("FAIL midop_async_reset: level=%0d busy=%b we=%b data=%h expected 0/0/0/00",
               prod_if.level, busy, we, data);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef LCD_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    int n = 0;
    do_reset();
    checks++;
    if (timeout !== 1'b0) $display("FAIL tmo_reset: timeout=%b expected 0", timeout); else passes++;
    lcd_init = 1'b1;
    lcd_ready = 1'b1;
    push_char(8'h54, 1'b1);
    wait_strobe(10, seen);
    while (timeout !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (timeout !== 1'b1 || n < 100 || n > 101 || busy !== 1'b0)
      $display("FAIL tmo_fire: timeout=%b after %0d cycles busy=%b expected 1 at 100..101/0", timeout, n, busy);
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if (timeout !== 1'b1) $display("FAIL tmo_sticky: timeout=%b expected 1", timeout); else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (timeout !== 1'b0) $display("FAIL tmo_clear: timeout=%b expected 0", timeout); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_full();
    test_simultaneous();
    test_reset_midop();
`ifdef LCD_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lcd_char_feeder.md
LCD_CHAR_FEEDER -- requirements
Module: lcd_char_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning character FIFO depth (power of two, 4..64).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the handshake watchdog limit in clocks (used only with LCD_FEEDER_TIMEOUT_EN).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: Clock  in  1  rising-edge clock.
REQ-004 SHALL have port Reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port iValid  in  1  producer offers a character.
REQ-006 SHALL have port iChar  in  8  character code.
REQ-007 SHALL have port oAccept  out  1  FIFO not full; a push happens when iValid and oAccept are both high at a rising edge.
REQ-008 SHALL have port iLCD_Ready  in  1  LCD driver idle and able to take a byte.
REQ-009 SHALL have port iLCD_Initialized  in  1  LCD power-on sequence finished.
REQ-010 SHALL have port oWrite_Enabled  out  1  one-cycle write strobe to the LCD driver.
REQ-011 SHALL have port oData  out  8  byte presented to the LCD driver.
REQ-012 SHALL have port oLevel  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port oBusy  out  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL derive oAccept combinationally as (oLevel != DEPTH); a full FIFO SHALL NOT bypass a push on a same-edge pop.
REQ-015 SHALL leave oLevel unchanged when a push and a pop occur at the same edge.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_BUSY and WAIT_READY.
REQ-017 IDLE SHALL move to ISSUE at an edge where the FIFO is non-empty, iLCD_Ready=1 and iLCD_Initialized=1; at that edge the FIFO head SHALL be loaded into oData and popped.
REQ-018 ISSUE SHALL last exactly one cycle, drive oWrite_Enabled=1, and then move to WAIT_BUSY; oWrite_Enabled SHALL be 0 in all other states.
REQ-019 WAIT_BUSY SHALL move to WAIT_READY when iLCD_Ready=0.
REQ-020 WAIT_READY SHALL move to IDLE when iLCD_Ready=1.
REQ-021 oData SHALL hold its value from the load until the next load, including all wait states.
REQ-022 Latency: a character pushed into an empty FIFO at edge N, with the LCD ready, SHALL produce oWrite_Enabled=1 during the cycle after edge N+1.
REQ-023 SHALL deliver characters strictly in FIFO order, with at most one strobe per character.
REQ-024 While iLCD_Initialized=0, the block SHALL keep accepting pushes until full and SHALL issue nothing.
REQ-025 Pointers SHALL wrap modulo DEPTH; oLevel SHALL range 0..DEPTH.

Reset
REQ-026 Reset_n=0 SHALL, asynchronously, set state=IDLE, empty the FIFO and force oLevel=0, oData=8'h00, oWrite_Enabled=0, oBusy=0 and oTimeout=0; this applies mid-handshake too.
REQ-027 After Reset_n rises, the first action SHALL occur no earlier than the first rising edge.

Configuration
REQ-028 With LCD_FEEDER_TIMEOUT_EN defined, the block SHALL add output port oTimeout (1 bit, sticky, cleared only by reset) and a counter active in WAIT_BUSY and WAIT_READY.
REQ-029 With LCD_FEEDER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in either wait state SHALL set oTimeout and return the block to IDLE; the character is treated as consumed.
REQ-030 Without LCD_FEEDER_TIMEOUT_EN, the oTimeout port and counter SHALL be absent and the wait states SHALL wait indefinitely.

Structure
REQ-031 Package lcd_feeder_pkg SHALL hold the state enumeration, CHAR_W=8 and the default DEPTH and TIMEOUT_CYCLES constants.
REQ-032 Storage SHALL be a sub-module char_fifo (synchronous push/pop, level output, asynchronous active-low reset); the sequencer SHALL live in lcd_char_feeder.

Verification
REQ-033 Basic: reset, iLCD_Initialized=1, iLCD_Ready=1, push 8'h41 -> oWrite_Enabled high for exactly one cycle, 2 edges after the push, with oData=8'h41.
REQ-034 Handshake: push 8'h48, 8'h49 with a model that drops iLCD_Ready 1 cycle after the strobe for 3000 cycles -> the second strobe (oData=8'h49) SHALL occur only after iLCD_Ready returns high.
REQ-035 Full: iLCD_Initialized=0, push 17 characters with DEPTH=16 -> oAccept=0 after 16 pushes and oLevel=16; raising iLCD_Initialized drains the 16 characters in order.
REQ-036 Simultaneous: a push and a pop at the same edge at oLevel=5 -> oLevel stays 5.
REQ-037 Reset mid-operation: assert Reset_n=0 in WAIT_BUSY with oLevel=3 -> oLevel=0, oBusy=0 and oWrite_Enabled=0 immediately, with no clock edge.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=100): hold iLCD_Ready=1 after the strobe -> oTimeout=1 after 100 cycles and the block returns to IDLE.
